// File: rtl/pli_monitor_pkg.sv
// Shared types and helpers for the pli_monitor checker-accumulator.
// State encoding is visible on state_o, so the enum values are fixed.
package pli_monitor_pkg;

    typedef enum logic [1:0] {
        ST_HOLDOFF  = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_STOPPING = 2'd2,
        ST_STOPPED  = 2'd3
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // a + b clipped to the largest w-bit value; operands are zero-extended.
    function automatic logic [63:0] sat_add(input int w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] max_v;
        logic [63:0] s;
        max_v = (64'd1 << w) - 64'd1;
        s     = a + b;
        return (s > max_v) ? max_v : s;
    endfunction

endpackage

// File: rtl/pli_monitor_if.sv
// Event inputs and status outputs of pli_monitor; slave is the monitor side,
// master is whoever drives the checker pulses and watches the status.
interface pli_monitor_if
    import pli_monitor_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int CNT_W = 16
) ();

    localparam int CW = chan_w(NCHAN);

    logic [NCHAN-1:0] err_i;
    logic [NCHAN-1:0] warn_i;
    logic             clear_i;
    logic             message_on_o;
    logic [CNT_W-1:0] errors_o;
    logic [CNT_W-1:0] warnings_o;
    logic [CW-1:0]    first_err_chan_o;
    logic             first_err_valid_o;
    logic             stop_req_o;
    logic [1:0]       state_o;

    modport master (
        output err_i, warn_i, clear_i,
        input  message_on_o, errors_o, warnings_o, first_err_chan_o,
               first_err_valid_o, stop_req_o, state_o
    );

    modport slave (
        input  err_i, warn_i, clear_i,
        output message_on_o, errors_o, warnings_o, first_err_chan_o,
               first_err_valid_o, stop_req_o, state_o
    );

endinterface

// File: rtl/pli_popcount_sat.sv
// Combinational: cnt + popcount(vec), clipped to 2^CNT_W-1. No state, no
// backpressure; the caller registers the result.
module pli_popcount_sat
    import pli_monitor_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int CNT_W = 16
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic [NCHAN-1:0] vec,
    output logic [CNT_W-1:0] sum
);

    localparam int PC_W = $clog2(NCHAN + 1);

    logic [PC_W-1:0] pc;

    always_comb begin
        pc = '0;
        for (int i = 0; i < NCHAN; i++) begin
            pc = pc + PC_W'(vec[i]);
        end
    end

    assign sum = CNT_W'(sat_add(CNT_W, 64'(cnt), 64'(pc)));

endmodule

// File: rtl/pli_monitor.sv
// Saturating error/warning accumulator with holdoff, first-error latch and sticky stop request.
// Totals update 1 cycle after the pulses; no backpressure. PLI_MONITOR_EXIT_ON_WARNING_EN lets warnings stop too.
module pli_monitor
    import pli_monitor_pkg::*;
#(
    parameter int NCHAN      = 4,
    parameter int CNT_W      = 16,
    parameter int ERR_LIMIT  = 1,
    parameter int WARN_LIMIT = 8,
    parameter int HOLDOFF    = 16,
    parameter int DRAIN      = 4
) (
    input  logic         clk,
    input  logic         reset,
    pli_monitor_if.slave mon
);

    localparam int CW    = chan_w(NCHAN);
    localparam int TMAX  = (HOLDOFF > DRAIN) ? HOLDOFF : DRAIN;
    localparam int TMR_W = chan_w(TMAX + 1);

`ifdef PLI_MONITOR_EXIT_ON_WARNING_EN
    localparam bit WARN_STOP = 1'b1;
`else
    localparam bit WARN_STOP = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] err_q, err_d, warn_q, warn_d;
    logic [CNT_W-1:0] err_sum, warn_sum;
    logic [CW-1:0]    fe_chan_q, fe_chan_d, low_idx;
    logic             fe_vld_q, fe_vld_d;
    logic             stop_q, stop_d;
    logic             trig, hold_done, drain_done;

    pli_popcount_sat #(.NCHAN(NCHAN), .CNT_W(CNT_W)) u_err_acc (
        .cnt (err_q),
        .vec (mon.err_i),
        .sum (err_sum)
    );

    pli_popcount_sat #(.NCHAN(NCHAN), .CNT_W(CNT_W)) u_warn_acc (
        .cnt (warn_q),
        .vec (mon.warn_i),
        .sum (warn_sum)
    );

    always_comb begin
        low_idx = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mon.err_i[i]) low_idx = CW'(i);
        end
    end

    // The shared timer holds the number of cycles already spent in the phase.
    assign hold_done  = (int'(tmr_q) + 1) >= HOLDOFF;
    assign drain_done = (int'(tmr_q) + 1) >= DRAIN;
    assign trig       = (err_sum >= CNT_W'(ERR_LIMIT)) |
                        (WARN_STOP & (warn_sum >= CNT_W'(WARN_LIMIT)));

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        err_d     = err_q;
        warn_d    = warn_q;
        fe_chan_d = fe_chan_q;
        fe_vld_d  = fe_vld_q;
        stop_d    = stop_q;
        if (state_q == ST_HOLDOFF) begin
            if (hold_done) begin
                state_d = ST_ACTIVE;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end else if (mon.clear_i) begin
            state_d   = ST_ACTIVE;
            tmr_d     = '0;
            err_d     = '0;
            warn_d    = '0;
            fe_chan_d = '0;
            fe_vld_d  = 1'b0;
            stop_d    = 1'b0;
        end else begin
            err_d  = err_sum;
            warn_d = warn_sum;
            if (!fe_vld_q && (|mon.err_i)) begin
                fe_vld_d  = 1'b1;
                fe_chan_d = low_idx;
            end
            case (state_q)
                ST_ACTIVE: begin
                    if (trig) begin
                        if (DRAIN == 0) begin
                            state_d = ST_STOPPED;
                            stop_d  = 1'b1;
                        end else begin
                            state_d = ST_STOPPING;
                            tmr_d   = '0;
                        end
                    end
                end
                ST_STOPPING: begin
                    if (drain_done) begin
                        state_d = ST_STOPPED;
                        stop_d  = 1'b1;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HOLDOFF;
            tmr_q     <= '0;
            err_q     <= '0;
            warn_q    <= '0;
            fe_chan_q <= '0;
            fe_vld_q  <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            warn_q    <= warn_d;
            fe_chan_q <= fe_chan_d;
            fe_vld_q  <= fe_vld_d;
            stop_q    <= stop_d;
        end
    end

    assign mon.message_on_o      = (state_q != ST_HOLDOFF);
    assign mon.errors_o          = err_q;
    assign mon.warnings_o        = warn_q;
    assign mon.first_err_chan_o  = fe_chan_q;
    assign mon.first_err_valid_o = fe_vld_q;
    assign mon.stop_req_o        = stop_q;
    assign mon.state_o           = state_q;

endmodule

// File: tb/tb_pli_monitor.sv
// Two monitor instances (4-channel with holdoff/drain, 1-channel with zero holdoff/drain)
// checked against a cycle-level behavioural model plus directed expectations.
`timescale 1ns/1ps
module tb_pli_monitor;
    import pli_monitor_pkg::*;

    localparam int A_N = 4, A_W = 4, A_EL = 3, A_WL = 8, A_HO = 16, A_DR = 4;
    localparam int B_N = 1, B_W = 3, B_EL = 2, B_WL = 5, B_HO = 0, B_DR = 0;
`ifdef PLI_MONITOR_EXIT_ON_WARNING_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   watch  = 1'b0;
    int   stop_rise = 0;

    pli_monitor_if #(.NCHAN(A_N), .CNT_W(A_W)) if_a ();
    pli_monitor_if #(.NCHAN(B_N), .CNT_W(B_W)) if_b ();

    pli_monitor #(.NCHAN(A_N), .CNT_W(A_W), .ERR_LIMIT(A_EL), .WARN_LIMIT(A_WL),
                  .HOLDOFF(A_HO), .DRAIN(A_DR)) dut_a (.clk(clk), .reset(reset), .mon(if_a));
    pli_monitor #(.NCHAN(B_N), .CNT_W(B_W), .ERR_LIMIT(B_EL), .WARN_LIMIT(B_WL),
                  .HOLDOFF(B_HO), .DRAIN(B_DR)) dut_b (.clk(clk), .reset(reset), .mon(if_b));

    always #5 clk = ~clk;

    // Reference model: totals as plain integers, phases as simple counters.
    typedef struct {
        bit hold;
        int hold_cnt;
        int e;
        int w;
        bit fe_vld;
        int fe_chan;
        bit stop;
        int drain_left;
    } model_t;

    function automatic model_t m_init();
        model_t m;
        m.hold = 1'b1; m.hold_cnt = 0; m.e = 0; m.w = 0;
        m.fe_vld = 1'b0; m.fe_chan = 0; m.stop = 1'b0; m.drain_left = 0;
        return m;
    endfunction

    function automatic model_t m_step(model_t m_in, int cnt_w, int elim, int wlim, int holdoff,
                                      int drain, logic [31:0] err, logic [31:0] warn, logic clr);
        model_t m = m_in;
        int maxv = (1 << cnt_w) - 1;
        bit was_active;
        logic [31:0] lsb;
        if (m.hold) begin
            m.hold_cnt++;
            if (m.hold_cnt >= holdoff) m.hold = 1'b0;
            return m;
        end
        if (clr) begin
            m = m_init();
            m.hold = 1'b0;
            return m;
        end
        was_active = !m.stop && (m.drain_left == 0);
        if (m.drain_left > 0) begin
            m.drain_left--;
            if (m.drain_left == 0) m.stop = 1'b1;
        end
        m.e = (m.e + $countones(err) > maxv) ? maxv : m.e + $countones(err);
        m.w = (m.w + $countones(warn) > maxv) ? maxv : m.w + $countones(warn);
        if (!m.fe_vld && err != 0) begin
            lsb = err & (~err + 32'd1);
            m.fe_chan = $clog2(lsb);
            m.fe_vld = 1'b1;
        end
        if (was_active && (m.e >= elim || (WARN_EN && m.w >= wlim))) begin
            if (drain == 0) m.stop = 1'b1;
            else m.drain_left = drain;
        end
        return m;
    endfunction

    function automatic int m_state(model_t m);
        if (m.hold) return 0;
        if (m.stop) return 3;
        if (m.drain_left > 0) return 2;
        return 1;
    endfunction

    model_t mA = m_init();
    model_t mB = m_init();

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mA <= m_init();
            mB <= m_init();
        end else begin
            mA <= m_step(mA, A_W, A_EL, A_WL, A_HO, A_DR, 32'(if_a.err_i), 32'(if_a.warn_i), if_a.clear_i);
            mB <= m_step(mB, B_W, B_EL, B_WL, B_HO, B_DR, 32'(if_b.err_i), 32'(if_b.warn_i), if_b.clear_i);
        end
    end

    always @(posedge if_a.stop_req_o) if (watch) stop_rise <= stop_rise + 1;

    function automatic logic [31:0] obs_a();
        return 32'({if_a.message_on_o, if_a.errors_o, if_a.warnings_o, if_a.first_err_chan_o,
                    if_a.first_err_valid_o, if_a.stop_req_o, if_a.state_o});
    endfunction

    function automatic logic [31:0] exp_a();
        return 32'({logic'(m_state(mA) != 0), A_W'(mA.e), A_W'(mA.w), 2'(mA.fe_chan),
                    logic'(mA.fe_vld), logic'(mA.stop), 2'(m_state(mA))});
    endfunction

    function automatic logic [31:0] obs_b();
        return 32'({if_b.message_on_o, if_b.errors_o, if_b.warnings_o, if_b.first_err_chan_o,
                    if_b.first_err_valid_o, if_b.stop_req_o, if_b.state_o});
    endfunction

    function automatic logic [31:0] exp_b();
        return 32'({logic'(m_state(mB) != 0), B_W'(mB.e), B_W'(mB.w), 1'(mB.fe_chan),
                    logic'(mB.fe_vld), logic'(mB.stop), 2'(m_state(mB))});
    endfunction

    task automatic set_a(input logic [3:0] e, input logic [3:0] w, input logic c);
        if_a.err_i = e; if_a.warn_i = w; if_a.clear_i = c;
    endtask

    task automatic set_b(input logic e, input logic w, input logic c);
        if_b.err_i = e; if_b.warn_i = w; if_b.clear_i = c;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_a(4'h0, 4'h0, 1'b0);
        set_b(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (obs_a() !== 32'd0) begin errors++; $display("FAIL reset_a got %h want 0", obs_a()); end
        checks++; if (obs_b() !== 32'd0) begin errors++; $display("FAIL reset_b got %h want 0", obs_b()); end
        reset = 1'b0;
    endtask

    task automatic test_holdoff();
        for (int k = 1; k <= A_HO + 2; k++) begin
            set_a((k == 5) ? 4'b0001 : 4'b0000, (k == 6) ? 4'b0010 : 4'b0000, k == 7);
            @(negedge clk);
            checks++; if (if_a.errors_o !== 4'd0) begin errors++; $display("FAIL hold_errors k=%0d got %0d want 0", k, if_a.errors_o); end
            checks++; if (if_a.message_on_o !== logic'(k >= A_HO)) begin errors++; $display("FAIL hold_msg_on k=%0d got %b want %b", k, if_a.message_on_o, k >= A_HO); end
            checks++; if (if_a.state_o !== ((k >= A_HO) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL hold_state k=%0d got %0d", k, if_a.state_o); end
            checks++; if (obs_a() !== exp_a()) begin errors++; $display("FAIL hold_model_a k=%0d got %h want %h", k, obs_a(), exp_a()); end
            if (k == 1) begin
                checks++; if (if_b.message_on_o !== 1'b1 || if_b.state_o !== 2'd1) begin errors++; $display("FAIL zero_holdoff_b got msg=%b st=%0d want 1/1", if_b.message_on_o, if_b.state_o); end
            end
        end
        set_a(4'h0, 4'h0, 1'b0);
    endtask

    task automatic test_zero_drain();
        set_b(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (if_b.errors_o !== 3'd1 || if_b.state_o !== 2'd1 || if_b.first_err_valid_o !== 1'b1 || if_b.first_err_chan_o !== 1'b0)
            begin errors++; $display("FAIL zd_first got %h want err=1 st=1 fe=0/1", obs_b()); end
        @(negedge clk);
        checks++; if (if_b.errors_o !== 3'd2 || if_b.state_o !== 2'd3 || if_b.stop_req_o !== 1'b1)
            begin errors++; $display("FAIL zd_stop got err=%0d st=%0d stop=%b want 2/3/1", if_b.errors_o, if_b.state_o, if_b.stop_req_o); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++; if (if_b.errors_o !== 3'((2 + k > 7) ? 7 : 2 + k)) begin errors++; $display("FAIL zd_sat k=%0d got %0d", k, if_b.errors_o); end
            checks++; if (obs_b() !== exp_b()) begin errors++; $display("FAIL zd_model k=%0d got %h want %h", k, obs_b(), exp_b()); end
        end
        set_b(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_b(1'b0, 1'b0, 1'b0);
        checks++; if (obs_b() !== exp_b() || if_b.state_o !== 2'd1) begin errors++; $display("FAIL zd_clear got %h want %h", obs_b(), exp_b()); end
    endtask

    task automatic test_simultaneous();
        set_a(4'b1010, 4'h0, 1'b0);
        @(negedge clk);
        checks++; if (if_a.errors_o !== 4'd2) begin errors++; $display("FAIL sim_errors got %0d want 2", if_a.errors_o); end
        checks++; if (if_a.first_err_chan_o !== 2'd1 || if_a.first_err_valid_o !== 1'b1) begin errors++; $display("FAIL sim_first got %0d/%b want 1/1", if_a.first_err_chan_o, if_a.first_err_valid_o); end
        set_a(4'b0100, 4'h0, 1'b0);
        @(negedge clk);
        set_a(4'h0, 4'h0, 1'b0);
        checks++; if (if_a.errors_o !== 4'd3 || if_a.state_o !== 2'd2 || if_a.first_err_chan_o !== 2'd1)
            begin errors++; $display("FAIL sim_limit got err=%0d st=%0d fe=%0d want 3/2/1", if_a.errors_o, if_a.state_o, if_a.first_err_chan_o); end
        for (int k = 1; k <= A_DR; k++) begin
            @(negedge clk);
            checks++; if (if_a.state_o !== ((k < A_DR) ? 2'd2 : 2'd3) || if_a.stop_req_o !== logic'(k == A_DR))
                begin errors++; $display("FAIL drain k=%0d got st=%0d stop=%b", k, if_a.state_o, if_a.stop_req_o); end
            checks++; if (obs_a() !== exp_a()) begin errors++; $display("FAIL drain_model k=%0d got %h want %h", k, obs_a(), exp_a()); end
        end
    endtask

    task automatic test_clear();
        set_a(4'b0001, 4'h0, 1'b0);
        @(negedge clk);
        checks++; if (if_a.errors_o !== 4'd4 || if_a.state_o !== 2'd3 || if_a.stop_req_o !== 1'b1)
            begin errors++; $display("FAIL stopped_count got err=%0d st=%0d stop=%b want 4/3/1", if_a.errors_o, if_a.state_o, if_a.stop_req_o); end
        set_a(4'b1111, 4'h0, 1'b1);
        @(negedge clk);
        set_a(4'h0, 4'h0, 1'b0);
        checks++; if (if_a.errors_o !== 4'd0 || if_a.stop_req_o !== 1'b0 || if_a.first_err_valid_o !== 1'b0 || if_a.state_o !== 2'd1)
            begin errors++; $display("FAIL clear got %h want err=0 stop=0 vld=0 st=1", obs_a()); end
        checks++; if (obs_a() !== exp_a()) begin errors++; $display("FAIL clear_model got %h want %h", obs_a(), exp_a()); end
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 5; k++) begin
            set_a(4'h0, 4'b1111, 1'b0);
            @(negedge clk);
            checks++; if (if_a.warnings_o !== 4'((4 * k > 15) ? 15 : 4 * k)) begin errors++; $display("FAIL warn_sat k=%0d got %0d", k, if_a.warnings_o); end
            checks++; if (if_a.state_o !== ((WARN_EN && k >= 2) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL warn_sat_state k=%0d got %0d", k, if_a.state_o); end
        end
        set_a(4'h0, 4'h0, 1'b1);
        @(negedge clk);
        set_a(4'h0, 4'h0, 1'b0);
        checks++; if (obs_a() !== exp_a() || if_a.warnings_o !== 4'd0) begin errors++; $display("FAIL sat_clear got %h want %h", obs_a(), exp_a()); end
    endtask

    task automatic test_warn_limit();
        for (int k = 1; k <= 4; k++) begin
            set_a(4'h0, 4'b0011, 1'b0);
            @(negedge clk);
            checks++; if (if_a.warnings_o !== 4'(2 * k)) begin errors++; $display("FAIL warn_lim k=%0d got %0d want %0d", k, if_a.warnings_o, 2 * k); end
            checks++; if (if_a.state_o !== ((WARN_EN && k == 4) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL warn_lim_state k=%0d got %0d", k, if_a.state_o); end
        end
        set_a(4'h0, 4'h0, 1'b1);
        @(negedge clk);
        set_a(4'h0, 4'h0, 1'b0);
    endtask

    task automatic test_reset_mid_stopping();
        set_a(4'b0111, 4'h0, 1'b0);
        @(negedge clk);
        set_a(4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (if_a.state_o !== 2'd2 || if_a.stop_req_o !== 1'b0) begin errors++; $display("FAIL mid_pre got st=%0d stop=%b want 2/0", if_a.state_o, if_a.stop_req_o); end
        watch = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++; if (obs_a() !== 32'd0) begin errors++; $display("FAIL mid_reset_a got %h want 0", obs_a()); end
        checks++; if (obs_b() !== 32'd0) begin errors++; $display("FAIL mid_reset_b got %h want 0", obs_b()); end
        repeat (3) @(negedge clk);
        checks++; if (obs_a() !== 32'd0) begin errors++; $display("FAIL mid_hold got %h want 0", obs_a()); end
        reset = 1'b0;
        @(negedge clk);
        watch = 1'b0;
        checks++; if (stop_rise !== 0) begin errors++; $display("FAIL stop_glitch got %0d rises want 0", stop_rise); end
        checks++; if (obs_a() !== exp_a() || if_a.state_o !== 2'd0) begin errors++; $display("FAIL mid_release got %h want %h", obs_a(), exp_a()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            set_a(4'($urandom & $urandom & $urandom), 4'($urandom & $urandom), $urandom_range(0, 15) == 0);
            set_b(1'($urandom & $urandom), 1'($urandom), $urandom_range(0, 11) == 0);
            @(negedge clk);
            checks++; if (obs_a() !== exp_a()) begin errors++; $display("FAIL rand_a n=%0d got %h want %h", n, obs_a(), exp_a()); end
            checks++; if (obs_b() !== exp_b()) begin errors++; $display("FAIL rand_b n=%0d got %h want %h", n, obs_b(), exp_b()); end
        end
    endtask

    initial begin
        test_reset();
        test_holdoff();
        test_zero_drain();
        test_simultaneous();
        test_clear();
        test_saturation();
        test_warn_limit();
        test_reset_mid_stopping();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pli_monitor.md
Name: pli_monitor

Overview:
- Parametrised successor to the simulation error/warning accumulator.
- Collects per-cycle error and warning pulses from NCHAN checker channels and keeps saturating totals.
- Gates checking during a post-reset holdoff, latches the first offending channel, and asserts a sticky stop request after a drain period.
- Sits at the top of the bench hierarchy; the bench calls $finish on stop_req_o.

Parameters:
- NCHAN, 4, number of checker channels (1..32).
- CNT_W, 16, width of the error and warning counters.
- ERR_LIMIT, 1, error total at which stopping begins (1..2^CNT_W-1).
- WARN_LIMIT, 8, warning total at which stopping begins; used only with the optional feature.
- HOLDOFF, 16, cycles after reset deassertion before message_on_o rises (0 allowed).
- DRAIN, 4, cycles spent in STOPPING before stop_req_o asserts (0 allowed).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- err_i  in  NCHAN  per-channel error pulses; each bit counts 1 per cycle high.
- warn_i  in  NCHAN  per-channel warning pulses; each bit counts 1 per cycle high.
- clear_i  in  1  synchronous clear of counters, first-error latch and stop.
- message_on_o  out  1  checking enabled (high in ACTIVE, STOPPING, STOPPED).
- errors_o  out  CNT_W  saturating error total.
- warnings_o  out  CNT_W  saturating warning total.
- first_err_chan_o  out  $clog2(NCHAN) (min 1)  index of the first channel that erred.
- first_err_valid_o  out  1  first_err_chan_o is valid.
- stop_req_o  out  1  sticky stop request.
- state_o  out  2  current state encoding.

Behaviour:
- Reset, asynchronous: all outputs 0; state HOLDOFF; holdoff/drain counter 0. Reset mid-operation aborts everything immediately, including STOPPING.
- States: HOLDOFF=0, ACTIVE=1, STOPPING=2, STOPPED=3.
- HOLDOFF:
  - err_i, warn_i and clear_i are ignored.
  - The counter counts cycles after reset release; at count HOLDOFF, move to ACTIVE.
  - HOLDOFF=0 means ACTIVE is entered on the first clock edge.
- Counting, in ACTIVE, STOPPING and STOPPED:
  - errors_o(next) = min(errors_o + popcount(err_i), 2^CNT_W-1).
  - warnings_o is updated the same way from warn_i.
  - Latency is 1 cycle. All simultaneous bits count.
  - The sum is formed at CNT_W+$clog2(NCHAN+1) bits before saturation.
- First-error latch:
  - On the first cycle with err_i != 0 while first_err_valid_o = 0, capture the lowest set index and set valid.
  - The latch holds until clear_i or reset.
- ACTIVE -> STOPPING: in the cycle where the next-state errors value is >= ERR_LIMIT. The transition is registered together with the counter update.
- STOPPING:
  - The drain counter runs from 0.
  - After DRAIN cycles, go to STOPPED and set stop_req_o.
  - DRAIN=0 means stop_req_o rises on the same edge as the state change into STOPPING's successor; STOPPING is skipped.
- STOPPED: terminal until clear_i; stop_req_o stays high; counters keep counting with saturation.
- clear_i, outside HOLDOFF:
  - Next cycle: counters = 0, first-error latch cleared, stop_req_o = 0, state ACTIVE.
  - Events in the clear cycle are discarded; clear has priority.
- Without the optional feature, warnings never cause stopping.

Optional Feature:
- Macro: PLI_MONITOR_EXIT_ON_WARNING_EN.
- Defined: ACTIVE -> STOPPING also triggers when next-state warnings_o >= WARN_LIMIT. Error and warning triggers are OR'd.
- Undefined: the WARN_LIMIT parameter is unused and warnings are purely informational.

Decomposition:
- Package pli_monitor_pkg contains:
  - the state typedef (2-bit enum HOLDOFF/ACTIVE/STOPPING/STOPPED);
  - a localparam helper function chan_w(n) returning max(1,$clog2(n));
  - a saturating-add function.
- Sub-module pli_popcount_sat:
  - Adds popcount of an NCHAN vector to a CNT_W value with saturation.
  - Instantiated twice, for errors and warnings.

Test Plan:
- Holdoff, HOLDOFF=16: pulse err_i=4'b0001 at cycle 5 after reset -> errors_o stays 0; message_on_o rises at cycle 16; state_o goes 0->1.
- Simultaneous events, ERR_LIMIT=3, DRAIN=4: err_i=4'b1010 in one cycle -> errors_o=2 next cycle and first_err_chan_o=1, valid=1. Then err_i=4'b0100 -> errors_o=3 and state STOPPING; 4 cycles later state STOPPED and stop_req_o=1.
- Saturation, CNT_W=4, ERR_LIMIT=15: drive warn_i=4'b1111 for 5 cycles -> warnings_o goes 4, 8, 12, 15, 15; no stop without the macro.
- Macro defined, WARN_LIMIT=8: warn_i=4'b0011 for 4 cycles -> warnings_o=8 on cycle 4 and STOPPING entered the same edge.
- clear_i in STOPPED with err_i=4'b1111 in the same cycle -> next cycle errors_o=0, stop_req_o=0, first_err_valid_o=0, state ACTIVE.
- Reset asserted mid-STOPPING (drain count 2) -> all outputs 0 and state HOLDOFF immediately; no stop_req_o glitch.
